// File: rtl/mem_unit.sv
// Unified instruction/data memory: IMEM, DMEM and constant ROM behind tag decode; fetch + load/store ports.
// Latency: 1 cycle, registered valid/err/rdata per port. Backpressure: none, a request is taken every cycle.
// Optional MISALIGN_CHECK_EN: misaligned half/word data accesses fault instead of being done byte-wise.
module mem_unit #(
  parameter int          IMEM_BYTES = 2048,
  parameter int          DMEM_BYTES = 4096,
  parameter logic [11:0] IMEM_BASE  = 12'h010,
  parameter logic [11:0] DMEM_BASE  = 12'h800,
  parameter logic [11:0] ROM_BASE   = 12'h001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err
);

  localparam int          IAW      = $clog2(IMEM_BYTES);
  localparam int          DAW      = $clog2(DMEM_BYTES);
  localparam logic [20:0] IMEM_LIM = 21'(IMEM_BYTES);
  localparam logic [20:0] DMEM_LIM = 21'(DMEM_BYTES);
  localparam logic [20:0] ROM_LIM  = 21'd12;

  logic [7:0] imem [IMEM_BYTES];
  logic [7:0] dmem [DMEM_BYTES];

  function automatic logic [7:0] rom_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_byte = 8'h95;
      4'd1:    rom_byte = 8'h91;
      4'd2:    rom_byte = 8'h71;
      4'd3:    rom_byte = 8'h11;
      4'd4:    rom_byte = 8'h76;
      4'd5:    rom_byte = 8'h29;
      4'd6:    rom_byte = 8'h03;
      4'd7:    rom_byte = 8'h16;
      4'd8:    rom_byte = 8'h26;
      4'd9:    rom_byte = 8'h94;
      4'd10:   rom_byte = 8'h75;
      4'd11:   rom_byte = 8'h11;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  // ---------------- fetch decode ----------------
  logic [11:0] i_tag;
  logic [19:0] i_off;
  logic [20:0] i_end;
  logic        i_fault;
  logic [31:0] i_word;

  assign i_tag   = i_addr[31:20];
  assign i_off   = i_addr[19:0];
  assign i_end   = {1'b0, i_off} + 21'd4;
  assign i_fault = (i_tag != IMEM_BASE) || (i_end > IMEM_LIM) || (i_addr[1:0] != 2'b00);

  // ---------------- data decode ----------------
  logic [11:0] d_tag;
  logic [19:0] d_off;
  logic [2:0]  d_size;
  logic        d_f3_bad;
  logic [20:0] d_end;
  logic        is_imem, is_dmem, is_rom;
  logic        d_misalign;
  logic        d_fault;
  logic [31:0] d_raw;
  logic [31:0] d_load;
  logic        d_commit;

  assign d_tag = d_addr[31:20];
  assign d_off = d_addr[19:0];

  always_comb begin
    d_size   = 3'd0;
    d_f3_bad = 1'b0;
    case (d_funct3)
      3'd0, 3'd4: d_size = 3'd1;
      3'd1, 3'd5: d_size = 3'd2;
      3'd2:       d_size = 3'd4;
      default:    d_f3_bad = 1'b1;
    endcase
  end

  assign d_end   = {1'b0, d_off} + {18'b0, d_size};
  assign is_imem = (d_tag == IMEM_BASE);
  assign is_dmem = (d_tag == DMEM_BASE);
  assign is_rom  = (d_tag == ROM_BASE);

`ifdef MISALIGN_CHECK_EN
  assign d_misalign = ((d_size == 3'd2) && d_addr[0]) ||
                      ((d_size == 3'd4) && (d_addr[1:0] != 2'b00));
`else
  assign d_misalign = 1'b0;
`endif

  always_comb begin
    d_fault = d_f3_bad || d_misalign;
    if (is_dmem)      d_fault = d_fault || (d_end > DMEM_LIM);
    else if (is_imem) d_fault = d_fault || (d_end > IMEM_LIM) || d_we;
    else if (is_rom)  d_fault = d_fault || (d_end > ROM_LIM) || d_we;
    else              d_fault = 1'b1;
  end

  // Four byte lanes at offset+k; misaligned accesses simply walk consecutive bytes.
  logic [DAW-1:0] d_didx [4];
  logic [IAW-1:0] d_iidx [4];
  logic [IAW-1:0] i_idx  [4];
  logic [3:0]     r_idx  [4];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign d_didx[k] = d_off[DAW-1:0] + DAW'(k);
    assign d_iidx[k] = d_off[IAW-1:0] + IAW'(k);
    assign i_idx[k]  = i_off[IAW-1:0] + IAW'(k);
    assign r_idx[k]  = d_off[3:0] + 4'(k);
    assign i_word[8*k +: 8] = imem[i_idx[k]];
    assign d_raw[8*k +: 8]  = is_dmem ? dmem[d_didx[k]] :
                              is_imem ? imem[d_iidx[k]] : rom_byte(r_idx[k]);
  end

  always_comb begin
    d_load = 32'h0;
    case (d_funct3)
      3'd0:    d_load = {{24{d_raw[7]}}, d_raw[7:0]};
      3'd1:    d_load = {{16{d_raw[15]}}, d_raw[15:0]};
      3'd2:    d_load = d_raw;
      3'd4:    d_load = {24'h0, d_raw[7:0]};
      3'd5:    d_load = {16'h0, d_raw[15:0]};
      default: d_load = 32'h0;
    endcase
  end

  // Requests seen while rst is high are dropped, so no write either.
  assign d_commit = d_req && d_we && !d_fault && !rst;

  // The IMEM write path only exists as the array's driver; the store-region rule keeps it idle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (d_commit && is_dmem && (3'(k) < d_size))
        dmem[d_didx[k]] <= d_wdata[8*k +: 8];
      if (d_commit && is_imem && (3'(k) < d_size))
        imem[d_iidx[k]] <= d_wdata[8*k +: 8];
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      i_valid <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= 32'h0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= 32'h0;
    end else begin
      i_valid <= i_req;
      i_err   <= i_req && i_fault;
      if (i_req)
        i_rdata <= i_fault ? 32'h0 : i_word;
      d_valid <= d_req;
      d_err   <= d_req && d_fault;
      if (d_req)
        d_rdata <= (d_fault || d_we) ? 32'h0 : d_load;
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit: ROM, byte/half stores, faults, misalignment, dual port, reset.
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_unit dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err)
  );

  always #5 clk = ~clk;

  // Presents one cycle of requests, then returns #1 after the accepting edge.
  task automatic issue(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a);
    issue(1'b0, 32'h0, 1'b1, 1'b0, f3, a, 32'h0);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(1'b0, 32'h0, 1'b1, 1'b1, f3, a, wd);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({i_valid, i_err, i_rdata, d_valid, d_err, d_rdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got iv=%b ie=%b ird=%h dv=%b de=%b drd=%h want all 0",
               i_valid, i_err, i_rdata, d_valid, d_err, d_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_rom;
    ld(3'd2, 32'h0010_0004);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'h1603_2976}) begin
      n_fail++; $display("FAIL rom_lw4: got v=%b e=%b d=%h want 1 0 16032976", d_valid, d_err, d_rdata);
    end
    ld(3'd4, 32'h0010_0001);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'h0000_0091}) begin
      n_fail++; $display("FAIL rom_lbu1: got v=%b e=%b d=%h want 1 0 00000091", d_valid, d_err, d_rdata);
    end
    ld(3'd0, 32'h0010_0001);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'hFFFF_FF91}) begin
      n_fail++; $display("FAIL rom_lb1: got v=%b e=%b d=%h want 1 0 ffffff91", d_valid, d_err, d_rdata);
    end
    ld(3'd4, 32'h0010_000B);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'h0000_0011}) begin
      n_fail++; $display("FAIL rom_lbu_last: got v=%b e=%b d=%h want 1 0 00000011", d_valid, d_err, d_rdata);
    end
    ld(3'd2, 32'h0010_000C);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rom_past_end: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
  endtask

  task automatic test_byte_half;
    st(3'd2, 32'h8000_0010, 32'hAABB_CCDD);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL store_resp: got v=%b e=%b d=%h want 1 0 00000000", d_valid, d_err, d_rdata);
    end
    st(3'd0, 32'h8000_0011, 32'h1234_565A);
    ld(3'd2, 32'h8000_0010);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'hAABB_5ADD}) begin
      n_fail++; $display("FAIL sb_merge: got v=%b e=%b d=%h want 1 0 aabb5add", d_valid, d_err, d_rdata);
    end
    ld(3'd1, 32'h8000_0012);
    n_checks++;
    if (d_rdata !== 32'hFFFF_AABB) begin
      n_fail++; $display("FAIL lh_sext: got %h want ffffaabb", d_rdata);
    end
    ld(3'd5, 32'h8000_0012);
    n_checks++;
    if (d_rdata !== 32'h0000_AABB) begin
      n_fail++; $display("FAIL lhu_zext: got %h want 0000aabb", d_rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({d_valid, d_rdata} !== {1'b0, 32'h0000_AABB}) begin
      n_fail++; $display("FAIL idle_hold: got v=%b d=%h want 0 0000aabb", d_valid, d_rdata);
    end
  endtask

  task automatic test_faults;
    st(3'd2, 32'h0100_0000, 32'hDEAD_BEEF);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL sw_imem: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
    ld(3'd2, 32'h8000_0010);
    ld(3'd2, 32'h4000_0000);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL lw_unmapped: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
    st(3'd2, 32'h8000_0FFC, 32'h0102_0304);
    st(3'd2, 32'h8000_0FFE, 32'hFFFF_FFFF);
    n_checks++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL sw_range: got e=%b want 1", d_err);
    end
    ld(3'd2, 32'h8000_0FFE);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL lw_range: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
    ld(3'd2, 32'h8000_0FFC);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b0, 32'h0102_0304}) begin
      n_fail++; $display("FAIL range_kept: got e=%b d=%h want 0 01020304", d_err, d_rdata);
    end
    ld(3'd3, 32'h8000_0010);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL f3_bad_load: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
    st(3'd3, 32'h8000_0010, 32'h0);
    st(3'd7, 32'h8000_0010, 32'h0);
    st(3'd2, 32'h0010_0000, 32'h0);
    n_checks++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL sw_rom: got e=%b want 1", d_err);
    end
    ld(3'd2, 32'h8000_0010);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b0, 32'hAABB_5ADD}) begin
      n_fail++; $display("FAIL f3_bad_nowrite: got e=%b d=%h want 0 aabb5add", d_err, d_rdata);
    end
    ld(3'd2, 32'h0010_0000);
    n_checks++;
    if (d_rdata !== 32'h1171_9195) begin
      n_fail++; $display("FAIL rom_intact: got %h want 11719195", d_rdata);
    end
  endtask

  task automatic test_misalign;
    st(3'd2, 32'h8000_0000, 32'h4433_2211);
    st(3'd2, 32'h8000_0004, 32'h8877_6655);
    ld(3'd2, 32'h8000_0002);
`ifdef MISALIGN_CHECK_EN
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL lw_misalign: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
    ld(3'd1, 32'h8000_0001);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL lh_misalign: got e=%b d=%h want 1 00000000", d_err, d_rdata);
    end
`else
    n_checks++;
    if ({d_err, d_rdata} !== {1'b0, 32'h6655_4433}) begin
      n_fail++; $display("FAIL lw_misalign: got e=%b d=%h want 0 66554433", d_err, d_rdata);
    end
    ld(3'd1, 32'h8000_0001);
    n_checks++;
    if ({d_err, d_rdata} !== {1'b0, 32'h0000_3322}) begin
      n_fail++; $display("FAIL lh_misalign: got e=%b d=%h want 0 00003322", d_err, d_rdata);
    end
`endif
  endtask

  task automatic test_dual;
    issue(1'b1, 32'h0100_0008, 1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'h0BAD_F00D);
    n_checks++;
    if ({i_valid, i_err, d_valid, d_err} !== 4'b1010) begin
      n_fail++; $display("FAIL dual_port: got iv=%b ie=%b dv=%b de=%b want 1 0 1 0", i_valid, i_err, d_valid, d_err);
    end
    ld(3'd2, 32'h8000_0000);
    n_checks++;
    if (d_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL dual_store: got %h want 0badf00d", d_rdata);
    end
    issue(1'b1, 32'h0100_0002, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if ({i_err, i_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL fetch_misalign: got e=%b d=%h want 1 00000000", i_err, i_rdata);
    end
    issue(1'b1, 32'h8000_0000, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if (i_err !== 1'b1) begin
      n_fail++; $display("FAIL fetch_dmem: got e=%b want 1", i_err);
    end
    issue(1'b1, 32'h0100_07FC, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if ({i_valid, i_err} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_last: got v=%b e=%b want 1 0", i_valid, i_err);
    end
    issue(1'b1, 32'h0100_0800, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if (i_err !== 1'b1) begin
      n_fail++; $display("FAIL fetch_range: got e=%b want 1", i_err);
    end
  endtask

  task automatic test_reset_mid;
    st(3'd2, 32'h8000_0020, 32'hCAFE_F00D);
    rst = 1'b1;
    st(3'd2, 32'h8000_0020, 32'h1234_5678);
    rst = 1'b0;
    n_checks++;
    if ({i_valid, i_err, i_rdata, d_valid, d_err, d_rdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got iv=%b ie=%b ird=%h dv=%b de=%b drd=%h want all 0",
               i_valid, i_err, i_rdata, d_valid, d_err, d_rdata);
    end
    ld(3'd2, 32'h8000_0020);
    n_checks++;
    if ({d_valid, d_err, d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL reset_no_write: got v=%b e=%b d=%h want 1 0 cafef00d", d_valid, d_err, d_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = 32'h0; d_wdata = 32'h0;
    test_reset();
    test_rom();
    test_byte_half();
    test_faults();
    test_misalign();
    test_dual();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
